// File: rtl/e203_exu_alu_share_arb_pkg.sv
// Shared constants, requester encodings and helpers for the shared-ALU arbiter.
package e203_exu_alu_share_arb_pkg;

    localparam int unsigned ALU_XLEN = 32;
    localparam int unsigned ALU_OPW  = 11;
    localparam int unsigned NREQ     = 3;

    // One-hot op bit positions on the datapath op vector
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_SLL  = 3;
    localparam int unsigned OP_SRL  = 4;
    localparam int unsigned OP_SRA  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_AND  = 7;
    localparam int unsigned OP_SLT  = 8;
    localparam int unsigned OP_SLTU = 9;
    localparam int unsigned OP_LUI  = 10;

    typedef enum logic [1:0] {
        REQ_RGLR = 2'd0,
        REQ_AGU  = 2'd1,
        REQ_MDV  = 2'd2
    } req_idx_e;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_st_e;

    // Next requester in round-robin order (mod 3)
    function automatic req_idx_e rr_next(input req_idx_e idx);
        case (idx)
            REQ_RGLR: rr_next = REQ_AGU;
            REQ_AGU:  rr_next = REQ_MDV;
            default:  rr_next = REQ_RGLR;
        endcase
    endfunction

    // Requester index to one-hot grant vector
    function automatic logic [NREQ-1:0] idx_onehot(input req_idx_e idx);
        case (idx)
            REQ_RGLR: idx_onehot = 3'b001;
            REQ_AGU:  idx_onehot = 3'b010;
            REQ_MDV:  idx_onehot = 3'b100;
            default:  idx_onehot = 3'b000;
        endcase
    endfunction

    // One-hot grant vector to requester index (zero vector maps to RGLR)
    function automatic req_idx_e onehot_idx(input logic [NREQ-1:0] gnt);
        if (gnt[2]) begin
            onehot_idx = REQ_MDV;
        end else if (gnt[1]) begin
            onehot_idx = REQ_AGU;
        end else begin
            onehot_idx = REQ_RGLR;
        end
    endfunction

endpackage

// File: rtl/e203_exu_alu_rr_pick.sv
// 3-way rotating priority pick: first valid requester starting at ptr_i wins.
module e203_exu_alu_rr_pick
    import e203_exu_alu_share_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    req_idx_e cand0;
    req_idx_e cand1;
    req_idx_e cand2;

    // Build the search order and grant the first valid candidate
    always_comb begin
        case (ptr_i)
            2'd1:    cand0 = REQ_AGU;
            2'd2:    cand0 = REQ_MDV;
            default: cand0 = REQ_RGLR;
        endcase
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        gnt_o = '0;
        if (valid_i[cand0]) begin
            gnt_o = idx_onehot(cand0);
        end else if (valid_i[cand1]) begin
            gnt_o = idx_onehot(cand1);
        end else if (valid_i[cand2]) begin
            gnt_o = idx_onehot(cand2);
        end
    end

endmodule

// File: rtl/e203_exu_alu_share_arb.sv
// Shared ALU datapath arbiter: round-robin between RGLR/AGU/MDV with
// optional multi-cycle lock by AGU/MDV. Zero-latency grant and mux.
// Optional lock timeout guarded by E203_ALU_ARB_LOCK_TMO_EN.
module e203_exu_alu_share_arb
    import e203_exu_alu_share_arb_pkg::*;
#(
    parameter int unsigned XLEN     = ALU_XLEN,
    parameter int unsigned OPW      = ALU_OPW,
    parameter int unsigned LOCK_MAX = 40
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            rglr_req_valid,
    input  logic [OPW-1:0]  rglr_req_op,
    input  logic [XLEN-1:0] rglr_req_op1,
    input  logic [XLEN-1:0] rglr_req_op2,
    output logic            rglr_gnt,

    input  logic            agu_req_valid,
    input  logic            agu_req_lock,
    input  logic [OPW-1:0]  agu_req_op,
    input  logic [XLEN-1:0] agu_req_op1,
    input  logic [XLEN-1:0] agu_req_op2,
    output logic            agu_gnt,

    input  logic            mdv_req_valid,
    input  logic            mdv_req_lock,
    input  logic [OPW-1:0]  mdv_req_op,
    input  logic [XLEN-1:0] mdv_req_op1,
    input  logic [XLEN-1:0] mdv_req_op2,
    output logic            mdv_gnt,

    output logic [OPW-1:0]  dp_op,
    output logic [XLEN-1:0] dp_op1,
    output logic [XLEN-1:0] dp_op2,
    input  logic [XLEN-1:0] dp_res,
    output logic [XLEN-1:0] arb_res,

    output logic            lock_tmo_err
);

    // A lock window shorter than two cycles cannot be meaningfully counted
    if (LOCK_MAX < 2) begin : g_lock_max_chk
        $error("LOCK_MAX must be at least 2");
    end

    lock_st_e lock_st_q, lock_st_d;
    req_idx_e owner_q,   owner_d;
    req_idx_e rr_ptr_q,  rr_ptr_d;

    logic [NREQ-1:0] req_vld;
    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] gnt;
    req_idx_e        gnt_idx;
    logic            gnt_lock;

`ifdef E203_ALU_ARB_LOCK_TMO_EN
    localparam int unsigned CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    assign req_vld = {mdv_req_valid, agu_req_valid, rglr_req_valid};

    e203_exu_alu_rr_pick u_rr_pick (
        .valid_i (req_vld),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt)
    );

    // Grant: owner only while locked, rotating pick otherwise; reset drops all
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (lock_st_q == LOCK_LOCKED) begin
                gnt = idx_onehot(owner_q) & req_vld;
            end else begin
                gnt = pick_gnt;
            end
        end
    end

    assign rglr_gnt = gnt[REQ_RGLR];
    assign agu_gnt  = gnt[REQ_AGU];
    assign mdv_gnt  = gnt[REQ_MDV];

    assign gnt_idx  = onehot_idx(gnt);
    assign gnt_lock = (gnt[REQ_AGU] & agu_req_lock) | (gnt[REQ_MDV] & mdv_req_lock);

    // Datapath mux; operands held at zero when nobody is granted
    always_comb begin
        dp_op  = '0;
        dp_op1 = '0;
        dp_op2 = '0;
        if (gnt[REQ_RGLR]) begin
            dp_op  = rglr_req_op;
            dp_op1 = rglr_req_op1;
            dp_op2 = rglr_req_op2;
        end else if (gnt[REQ_AGU]) begin
            dp_op  = agu_req_op;
            dp_op1 = agu_req_op1;
            dp_op2 = agu_req_op2;
        end else if (gnt[REQ_MDV]) begin
            dp_op  = mdv_req_op;
            dp_op1 = mdv_req_op1;
            dp_op2 = mdv_req_op2;
        end
    end

    assign arb_res = dp_res;

    // Lock FSM and round-robin pointer next state
    always_comb begin
        lock_st_d = lock_st_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef E203_ALU_ARB_LOCK_TMO_EN
        cnt_d     = cnt_q;
        tmo_err_d = 1'b0;
`endif
        case (lock_st_q)
            LOCK_UNLOCKED: begin
                if (|gnt) begin
                    rr_ptr_d = rr_next(gnt_idx);
                    if (gnt_lock) begin
                        lock_st_d = LOCK_LOCKED;
                        owner_d   = gnt_idx;
`ifdef E203_ALU_ARB_LOCK_TMO_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            default: begin
                if ((|gnt) && !gnt_lock) begin
                    lock_st_d = LOCK_UNLOCKED;
                    rr_ptr_d  = rr_next(owner_q);
                end
`ifdef E203_ALU_ARB_LOCK_TMO_EN
                else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    lock_st_d = LOCK_UNLOCKED;
                    rr_ptr_d  = rr_next(owner_q);
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_st_q <= LOCK_UNLOCKED;
            owner_q   <= REQ_RGLR;
            rr_ptr_q  <= REQ_RGLR;
`ifdef E203_ALU_ARB_LOCK_TMO_EN
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
            lock_st_q <= lock_st_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef E203_ALU_ARB_LOCK_TMO_EN
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
`endif
        end
    end

`ifdef E203_ALU_ARB_LOCK_TMO_EN
    assign lock_tmo_err = tmo_err_q;
`else
    assign lock_tmo_err = 1'b0;
`endif

endmodule
